// File: rtl/ram_arbiter.sv
// Two-requester round-robin front end for a single-port synchronous RAM.
// Clears the RAM after reset, then grants one access per cycle.
module ram_arbiter #(
    parameter int                 DATA_W   = 8,
    parameter int                 ADDR_W   = 3,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              init_done,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_out
);

    typedef enum logic {INIT, ARB} state_t;

    localparam logic [ADDR_W-1:0] CNT_MAX = '1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              last;

    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            cnt       <= '0;
            last      <= 1'b1;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            init_done <= (state_nxt == ARB);
            if (state == INIT)
                cnt <= cnt + 1'b1;
            if (gnt0)
                last <= 1'b0;
            else if (gnt1)
                last <= 1'b1;
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_data_in = '0;
        // Reset gates the RAM port so a mid-operation reset never writes.
        if (!rst) begin
            case (state)
                INIT: begin
                    ram_we      = 1'b1;
                    ram_addr    = cnt;
                    ram_data_in = INIT_VAL;
                    if (cnt == CNT_MAX)
                        state_nxt = ARB;
                end
                ARB: begin
                    // On a tie requester 0 wins only when 1 went last.
                    if (req0 && (!req1 || last))
                        gnt0 = 1'b1;
                    else if (req1)
                        gnt1 = 1'b1;
                    if (gnt0) begin
                        ram_we      = we0;
                        ram_addr    = addr0;
                        ram_data_in = wdata0;
                    end else if (gnt1) begin
                        ram_we      = we1;
                        ram_addr    = addr1;
                        ram_data_in = wdata1;
                    end
                end
                default: state_nxt = INIT;
            endcase
        end
    end

    assign rdata0 = ram_out;
    assign rdata1 = ram_out;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM plus a transaction-level reference
// model (request queues, expected memory image) checked every cycle.
module tb_ram_arbiter;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
    localparam logic [DW-1:0] INIT_V = 8'h00;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, init_done, ram_we;
    logic [DW-1:0] rdata0, rdata1, ram_data_in;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_out = '0;
    logic [DW-1:0] ram_mem [DEPTH];

    ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .INIT_VAL(INIT_V)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .init_done(init_done),
        .ram_data_in(ram_data_in), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_out(ram_out)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM: out holds the location addressed last cycle.
    always @(posedge clk) begin
        if (ram_we)
            ram_mem[ram_addr] <= ram_data_in;
        ram_out <= ram_mem[ram_addr];
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    op_t q0[$];
    op_t q1[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, advanced once per clock edge.
    int            sweep = 0;
    bit            m_last = 1'b1;
    bit            m_rv0 = 1'b0, m_rv1 = 1'b0;
    logic [DW-1:0] m_rd0 = '0, m_rd1 = '0;
    logic [DW-1:0] ref_mem [DEPTH];

    // Observations of DUT behaviour for the directed scenario checks.
    logic [DW-1:0] obs0[$];
    logic [DW-1:0] obs1[$];
    int            gorder[$];
    int            first_g0 = -1, first_g1 = -1;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic drive();
        req0 = (q0.size() > 0);
        req1 = (q1.size() > 0);
        if (req0) begin
            we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].data;
        end else begin
            we0 = 1'($urandom); addr0 = AW'($urandom); wdata0 = DW'($urandom);
        end
        if (req1) begin
            we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].data;
        end else begin
            we1 = 1'($urandom); addr1 = AW'($urandom); wdata1 = DW'($urandom);
        end
    endtask

    task automatic step();
        int  win;
        bit  in_init;
        op_t op;
        drive();
        @(negedge clk);
        in_init = (sweep < DEPTH);
        win = -1;
        if (!rst && !in_init) begin
            if (req0 && req1)
                win = m_last ? 0 : 1;
            else if (req0)
                win = 0;
            else if (req1)
                win = 1;
        end
        if (win == 0) op = q0[0];
        if (win == 1) op = q1[0];

        check("gnt0", 32'(gnt0), 32'(win == 0));
        check("gnt1", 32'(gnt1), 32'(win == 1));
        check("init_done", 32'(init_done), 32'(sweep >= DEPTH));
        check("rvalid0", 32'(rvalid0), 32'(m_rv0));
        check("rvalid1", 32'(rvalid1), 32'(m_rv1));
        if (m_rv0) check("rdata0", 32'(rdata0), 32'(m_rd0));
        if (m_rv1) check("rdata1", 32'(rdata1), 32'(m_rd1));
        if (rst) begin
            check("ram_we_rst", 32'(ram_we), 32'd0);
        end else if (in_init) begin
            check("sweep_we", 32'(ram_we), 32'd1);
            check("sweep_addr", 32'(ram_addr), 32'(sweep));
            check("sweep_data", 32'(ram_data_in), 32'(INIT_V));
        end else if (win >= 0) begin
            check("acc_we", 32'(ram_we), 32'(op.we));
            check("acc_addr", 32'(ram_addr), 32'(op.addr));
            if (op.we) check("acc_data", 32'(ram_data_in), 32'(op.data));
        end else begin
            check("idle_we", 32'(ram_we), 32'd0);
            check("idle_addr", 32'(ram_addr), 32'd0);
            check("idle_data", 32'(ram_data_in), 32'd0);
        end

        if (rvalid0) obs0.push_back(rdata0);
        if (rvalid1) obs1.push_back(rdata1);
        if (gnt0) begin gorder.push_back(0); if (first_g0 < 0) first_g0 = sweep; end
        if (gnt1) begin gorder.push_back(1); if (first_g1 < 0) first_g1 = sweep; end

        // Advance the model across the coming edge.
        if (rst) begin
            sweep = 0; m_last = 1'b1; m_rv0 = 1'b0; m_rv1 = 1'b0;
        end else begin
            if (in_init) ref_mem[sweep] = INIT_V;
            m_rv0 = 1'b0;
            m_rv1 = 1'b0;
            if (win >= 0) begin
                if (win == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                if (op.we)
                    ref_mem[op.addr] = op.data;
                else if (win == 0) begin
                    m_rv0 = 1'b1; m_rd0 = ref_mem[op.addr];
                end else begin
                    m_rv1 = 1'b1; m_rd1 = ref_mem[op.addr];
                end
                m_last = (win == 1);
            end
            if (sweep < 1000) sweep++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_rv0 || m_rv1) && n < 200) begin
            step();
            n++;
        end
        check(tag, 32'(n < 200), 32'd1);
    endtask

    function automatic op_t mk(input logic we, input int a, input int d);
        op_t o;
        o.we = we; o.addr = AW'(a); o.data = DW'(d);
        return o;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        first_g0 = -1;
        first_g1 = -1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = DW'($urandom) | 8'h01;
            ref_mem[i] = 'x;
        end

        // Reset, clear sweep, request held off during INIT.
        do_reset();
        q0.push_back(mk(0, 4, 0));
        obs0.delete();
        drain("drain_init");
        check("first_gnt0_cycle", 32'(first_g0), 32'd8);
        check("init_read_cnt", 32'(obs0.size()), 32'd1);
        if (obs0.size() == 1) check("init_read_val", 32'(obs0[0]), 32'h00);

        // Writes then reads from one requester.
        q0.push_back(mk(1, 4, 8'h11));
        q0.push_back(mk(1, 2, 8'hAC));
        q0.push_back(mk(1, 4, 8'hAB));
        q0.push_back(mk(0, 4, 0));
        q0.push_back(mk(0, 2, 0));
        obs0.delete();
        drain("drain_wr");
        check("wr_read_cnt", 32'(obs0.size()), 32'd2);
        if (obs0.size() == 2) begin
            check("wr_read_a4", 32'(obs0[0]), 32'hAB);
            check("wr_read_a2", 32'(obs0[1]), 32'hAC);
        end

        // Requester 1 goes once so requester 0 wins the following tie.
        q1.push_back(mk(0, 2, 0));
        drain("drain_pre_tie");
        q0.push_back(mk(0, 4, 0)); q0.push_back(mk(0, 4, 0));
        q1.push_back(mk(0, 2, 0)); q1.push_back(mk(0, 2, 0));
        obs0.delete(); obs1.delete(); gorder.delete();
        drain("drain_tie");
        check("tie_gnt_cnt", 32'(gorder.size()), 32'd4);
        if (gorder.size() == 4)
            for (int k = 0; k < 4; k++) check("tie_order", 32'(gorder[k]), 32'(k % 2));
        check("tie_rv_cnt", 32'(obs0.size() + obs1.size()), 32'd4);
        if (obs0.size() == 2 && obs1.size() == 2) begin
            check("tie_rd0", 32'(obs0[1]), 32'hAB);
            check("tie_rd1", 32'(obs1[1]), 32'hAC);
        end

        // Cross-requester write then read of the same address.
        q1.push_back(mk(1, 7, 8'h5A));
        step();
        q0.push_back(mk(0, 7, 0));
        obs0.delete();
        drain("drain_fwd");
        check("fwd_cnt", 32'(obs0.size()), 32'd1);
        if (obs0.size() == 1) check("fwd_val", 32'(obs0[0]), 32'h5A);

        // Reset while a read of a freshly written address is requested.
        q0.push_back(mk(1, 1, 8'h33));
        drain("drain_pre_rst");
        q0.push_back(mk(0, 1, 0));
        obs0.delete(); obs1.delete();
        do_reset();
        drain("drain_mid_rst");
        check("rst_read_cnt", 32'(obs0.size()), 32'd1);
        if (obs0.size() == 1) check("rst_read_val", 32'(obs0[0]), 32'h00);
        check("rst_first_gnt0", 32'(first_g0), 32'd8);

        // Requester 1 asks from reset release.
        do_reset();
        q1.push_back(mk(0, 3, 0));
        drain("drain_init1");
        check("first_gnt1_cycle", 32'(first_g1), 32'd8);

        // Random traffic from both requesters.
        for (int c = 0; c < 400; c++) begin
            if (q0.size() < 2 && $urandom_range(2) == 0)
                q0.push_back(mk(1'($urandom), int'($urandom_range(DEPTH - 1)), int'($urandom_range(255))));
            if (q1.size() < 2 && $urandom_range(2) == 0)
                q1.push_back(mk(1'($urandom), int'($urandom_range(DEPTH - 1)), int'($urandom_range(255))));
            step();
        end
        drain("drain_rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
